// File: rtl/joystick_serial_responder.sv
// Device-side joystick responder: snapshots X/Y/buttons while latch is high, then
// shifts the frame out MSB-first, one bit per host pulse. Optional macro: JOYSTICK_PARITY_EN.
module joystick_serial_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        IDLE_LEVEL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       latch,
  input  logic       pulse,
  input  logic [7:0] position_x,
  input  logic [7:0] position_y,
  input  logic [4:0] buttons,
  output logic       data_out,
  output logic       busy,
  output logic       frame_done
);

`ifdef JOYSTICK_PARITY_EN
  localparam int unsigned FRAME_BITS = 22;
`else
  localparam int unsigned FRAME_BITS = 21;
`endif
  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e                 r_state, w_state_next;
  logic [SYNC_STAGES-1:0] r_latch_sync, r_pulse_sync;
  logic                   r_latch_prev, r_pulse_prev;
  logic                   w_latch_s, w_pulse_s;
  logic                   w_latch_rise, w_latch_fall, w_pulse_rise;
  logic [FRAME_BITS-1:0]  r_shift, w_frame;
  logic [4:0]             r_cnt;
  logic                   r_data_out, r_frame_done;
  logic                   w_data_out_d, w_frame_done_d, w_busy;

`ifdef JOYSTICK_PARITY_EN
  assign w_frame = {position_x, position_y, buttons, ^{position_x, position_y, buttons}};
`else
  assign w_frame = {position_x, position_y, buttons};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_latch_sync <= '0;
      r_pulse_sync <= '0;
      r_latch_prev <= 1'b0;
      r_pulse_prev <= 1'b0;
    end else begin
      r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], latch};
      r_pulse_sync <= {r_pulse_sync[SYNC_STAGES-2:0], pulse};
      r_latch_prev <= w_latch_s;
      r_pulse_prev <= w_pulse_s;
    end
  end

  assign w_latch_s    = r_latch_sync[SYNC_STAGES-1];
  assign w_pulse_s    = r_pulse_sync[SYNC_STAGES-1];
  assign w_latch_rise = w_latch_s & ~r_latch_prev;
  assign w_latch_fall = ~w_latch_s & r_latch_prev;
  assign w_pulse_rise = w_pulse_s & ~r_pulse_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_latch_s) w_state_next = StLoad;
      StLoad:  if (w_latch_fall) w_state_next = StShift;
      StShift: begin
        // A latch rise aborts the frame and takes priority over a coincident pulse.
        if (w_latch_rise) begin
          w_state_next = StLoad;
        end else if (w_pulse_rise && !w_latch_s && r_cnt == LAST_BIT) begin
          w_state_next = StDone;
        end
      end
      StDone:  if (w_latch_s) w_state_next = StLoad;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_busy         = (r_state == StLoad) || (r_state == StShift);
    w_frame_done_d = (r_state == StShift) && (w_state_next == StDone);
    w_data_out_d   = IDLE_LEVEL;
    if (w_busy && w_state_next != StDone) begin
      w_data_out_d = r_shift[FRAME_BITS-1];
    end
  end

  // The snapshot stops reloading on the cycle latch falls, freezing the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_state_next == StLoad) begin
      r_shift <= w_frame;
      r_cnt   <= '0;
    end else if (r_state == StShift && w_pulse_rise && !w_latch_s && r_cnt != LAST_BIT) begin
      r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
      r_cnt   <= r_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out   <= IDLE_LEVEL;
      r_frame_done <= 1'b0;
    end else begin
      r_data_out   <= w_data_out_d;
      r_frame_done <= w_frame_done_d;
    end
  end

  assign data_out   = r_data_out;
  assign frame_done = r_frame_done;
  assign busy       = w_busy;

endmodule

// File: tb/tb_joystick_serial_responder.sv
// Self-checking bench for joystick_serial_responder: a frame-level model predicts the
// settled serial bit, busy and frame_done count after every host latch/pulse action.
`timescale 1ns/1ps
module tb_joystick_serial_responder;

`ifdef JOYSTICK_PARITY_EN
  localparam int   FRAME_BITS = 22;
  localparam logic FULL_PAR   = 1'b1;  // A5/3C/10011 has 11 ones
`else
  localparam int   FRAME_BITS = 21;
  localparam logic FULL_PAR   = 1'b0;  // no parity bit captured
`endif
  localparam logic IDLE_LEVEL = 1'b0;
  localparam int   SETTLE     = 6;

  typedef enum int {MIdle, MLoad, MShift, MDone} mode_e;

  logic       clk = 1'b0, reset_n = 1'b0, latch = 1'b0, pulse = 1'b0;
  logic [7:0] position_x = 8'h00, position_y = 8'h00;
  logic [4:0] buttons = 5'b0;
  logic       data_out, busy, frame_done;

  int    checks = 0, errors = 0;
  logic  chk_en = 1'b0;
  logic  exp_data = IDLE_LEVEL, exp_busy = 1'b0;
  int    exp_fd = 0, fd_cycles = 0;
  mode_e mode = MIdle;
  logic [21:0] snap, obs, f;
  int    idx = 0;

  joystick_serial_responder #(
    .SYNC_STAGES(2),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .latch     (latch),
    .pulse     (pulse),
    .position_x(position_x),
    .position_y(position_y),
    .buttons   (buttons),
    .data_out  (data_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #10 clk = ~clk;

  // Frame as a 22-bit vector: bit i of the stream is at position 21-i; last bit is parity.
  function automatic logic [21:0] frame_of(input logic [7:0] x, input logic [7:0] y,
                                           input logic [4:0] b);
    logic [20:0] d;
    d = {x, y, b};
    return {d, ^d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("data_out", 32'(data_out), 32'(exp_data));
      check("busy", 32'(busy), 32'(exp_busy));
      check("frame_done_quiet", 32'(frame_done), 32'd0);
    end
    if (frame_done) begin
      fd_cycles++;
      check("done_busy_low", 32'(busy), 32'd0);
      check("done_data_idle", 32'(data_out), 32'(IDLE_LEVEL));
    end
  end

  task automatic do_latch(input logic with_pulse);
    chk_en = 1'b0;
    latch  = 1'b1;
    pulse  = with_pulse;
    tick(SETTLE);
    mode     = MLoad;
    exp_busy = 1'b1;
    f        = frame_of(position_x, position_y, buttons);
    exp_data = f[21];
    chk_en   = 1'b1;
    tick(4);
    chk_en = 1'b0;
    latch  = 1'b0;
    pulse  = 1'b0;
    snap   = frame_of(position_x, position_y, buttons);
    idx    = 0;
    mode   = MShift;
    tick(SETTLE);
    obs     = '0;
    obs[21] = data_out;
    chk_en  = 1'b1;
  endtask

  task automatic do_pulse();
    chk_en = 1'b0;
    pulse  = 1'b1;
    tick(SETTLE);
    if (mode == MShift) begin
      idx++;
      if (idx == FRAME_BITS) begin
        mode     = MDone;
        exp_data = IDLE_LEVEL;
        exp_busy = 1'b0;
        exp_fd++;
      end else begin
        exp_data      = snap[21-idx];
        obs[21-idx]   = data_out;
      end
    end
    check("frame_done_count", 32'(fd_cycles), 32'(exp_fd));
    chk_en = 1'b1;
    tick(4);
    pulse = 1'b0;
    tick(10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    // Pin the model against hand-computed frames.
    f = frame_of(8'hA5, 8'h3C, 5'b10011);
    check("model_frame_a", 32'(f[21:1]), 32'h14A793);
    check("model_parity_a", 32'(f[0]), 32'd1);
    f = frame_of(8'hA5, 8'h3C, 5'b10010);
    check("model_frame_b", 32'(f[21:1]), 32'h14A792);
    check("model_parity_b", 32'(f[0]), 32'd0);

    // Reset held with latch/pulse activity: outputs stay idle.
    #2;
    chk_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      latch = ~latch;
      tick(1);
      pulse = ~pulse;
      tick(2);
    end
    latch = 1'b0;
    pulse = 1'b0;
    tick(3);
    check("reset_no_done", 32'(fd_cycles), 32'd0);
    reset_n = 1'b1;
    tick(5);

    // Full frame.
    position_x = 8'hA5;
    position_y = 8'h3C;
    buttons    = 5'b10011;
    do_latch(1'b0);
    repeat (FRAME_BITS) do_pulse();
    check("stream_full", 32'(obs), 32'({21'h14A793, FULL_PAR}));
    check("done_once_full", 32'(fd_cycles), 32'd1);

    // Snapshot freeze: change X after latch falls.
    do_latch(1'b0);
    position_x = 8'hFF;
    repeat (FRAME_BITS) do_pulse();
    check("stream_frozen", 32'(obs), 32'({21'h14A793, FULL_PAR}));

    // Next latch captures the new X; abort after 7 pulses.
    do_latch(1'b0);
    repeat (7) do_pulse();
    check("next_capture_x", 32'(obs[21:15]), 32'(7'h7F));
    position_x = 8'h25;
    do_latch(1'b0);
    check("abort_no_done", 32'(fd_cycles), 32'(exp_fd));
    check("abort_first_bit", 32'(data_out), 32'd0);
    repeat (FRAME_BITS) do_pulse();
    f = frame_of(8'h25, 8'h3C, 5'b10011);
    check("stream_after_abort", 32'(obs), 32'(f & (FRAME_BITS == 22 ? 22'h3FFFFF : 22'h3FFFFE)));

    // Latch and pulse rise together: latch wins, then extra pulses in DONE are ignored.
    position_x = 8'hA5;
    do_latch(1'b1);
    check("simul_first_bit", 32'(data_out), 32'd1);
    repeat (FRAME_BITS) do_pulse();
    check("stream_simul", 32'(obs), 32'({21'h14A793, FULL_PAR}));
    repeat (3) do_pulse();
    check("extra_pulse_idle", 32'(data_out), 32'(IDLE_LEVEL));

    // Second button pattern.
    buttons = 5'b10010;
    do_latch(1'b0);
    repeat (FRAME_BITS) do_pulse();
    check("stream_buttons_b", 32'(obs), 32'({21'h14A792, 1'b0}));

    // Reset in the middle of a frame.
    do_latch(1'b0);
    repeat (3) do_pulse();
    chk_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midreset_data", 32'(data_out), 32'(IDLE_LEVEL));
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(frame_done), 32'd0);
    mode     = MIdle;
    exp_data = IDLE_LEVEL;
    exp_busy = 1'b0;
    chk_en   = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(5);
    check("midreset_no_done", 32'(fd_cycles), 32'(exp_fd));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
